// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_master
//  Description : Burst initiator for one port of the dual-port main memory.
//                Accepts a burst command (base, length, direction), presents
//                one word per cycle on the memory port, takes write data
//                from a valid/ready stream and returns read data as a
//                valid-qualified stream.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                start, op_write,
//                base_addr, length     - burst command (sampled in IDLE)
//                busy, done            - burst status / completion pulse
//                wr_data, wr_valid,
//                wr_ready              - write stream in
//                rd_data, rd_valid     - read stream out (no backpressure)
//                mem_address, mem_data,
//                mem_wren, mem_q       - memory port (address_x/data_x/
//                                        wren_x/q_x)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_master #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 24,
    parameter int LEN_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_write,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WRITE = 3'd1;
    localparam logic [2:0] c_ST_READ  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;      // next address to present
    logic [LEN_W-1:0]  r_remain;    // words not yet presented
    logic [RD_LAT-1:0] r_pipe;      // one token per read address in flight

    logic w_accept;
    logic w_wr_fire;
    logic w_rd_first;
    logic w_rd_issue;

    assign w_accept   = (r_state == c_ST_IDLE) && start;
    assign w_wr_fire  = wr_valid && wr_ready;
    // A read burst presents its first address in the accepting cycle so the
    // address is on the port the cycle after start.
    assign w_rd_first = w_accept && !op_write && (length != '0);
    assign w_rd_issue = w_rd_first || (r_state == c_ST_READ);

    // WRITE lingers one cycle with r_remain == 0 so the last word is on the
    // port before DONE; that keeps mem_wren low while done is high.
    assign wr_ready = (r_state == c_ST_WRITE) && (r_remain != '0);
    assign busy     = (r_state == c_ST_WRITE) || (r_state == c_ST_READ) ||
                      (r_state == c_ST_DRAIN);
    assign done     = (r_state == c_ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (op_write) begin
                        w_state_nxt = c_ST_WRITE;
                    end else if (length == LEN_W'(1)) begin
                        w_state_nxt = c_ST_DRAIN;
                    end else begin
                        w_state_nxt = c_ST_READ;
                    end
                end
            end
            c_ST_WRITE: begin
                if (r_remain == '0) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_READ: begin
                if (r_remain == LEN_W'(1)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // Leaves the cycle the last token surfaces on rd_valid, so
                // done follows the final rd_valid without overlap.
                if (r_pipe == '0) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_pipe      <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            rd_valid <= r_pipe[RD_LAT-1];
            if (r_pipe[RD_LAT-1]) begin
                rd_data <= mem_q;
            end
            r_pipe[0] <= w_rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_rd_first) begin
                mem_address <= base_addr;
                r_addr      <= base_addr + ADDR_W'(1);
                r_remain    <= length - LEN_W'(1);
            end else if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= length;
            end

            if (w_wr_fire) begin
                mem_address <= r_addr;
                mem_data    <= wr_data;
                mem_wren    <= 1'b1;
                r_addr      <= r_addr + ADDR_W'(1);
                r_remain    <= r_remain - LEN_W'(1);
            end

            if (r_state == c_ST_READ) begin
                mem_address <= r_addr;
                r_addr      <= r_addr + ADDR_W'(1);
                r_remain    <= r_remain - LEN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_burst_master
//  Description : Directed self-checking bench for mem_burst_master with a
//                negedge-clocked memory model and a transaction-level
//                expectation model (expected writes / expected read
//                addresses, shadow memory for read data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_master;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 24;
    localparam int LEN_W  = 10;
    localparam int RD_LAT = 1;
    localparam int AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              op_write;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q = '0;

    always #5 clk = ~clk;

    mem_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_write(op_write),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_address(mem_address),
        .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [23:0] init_pat(input int a);
        return 24'(a) ^ 24'h5A5A5A;
    endfunction

    // Memory model: clocked on the inverted clock, read-before-write.
    logic [23:0] tb_mem [int];
    always @(negedge clk) begin
        mem_q <= tb_mem.exists(int'(mem_address)) ? tb_mem[int'(mem_address)]
                                                  : init_pat(int'(mem_address));
        if (mem_wren) tb_mem[int'(mem_address)] = mem_data;
    end

    // Expectation model.
    typedef struct { int addr; int data; } wr_t;
    wr_t         exp_wr_q[$];
    int          exp_rd_q[$];
    logic [23:0] shadow [int];

    function automatic int shadow_rd(input int a);
        return shadow.exists(a) ? int'(shadow[a]) : int'(init_pat(a));
    endfunction

    task automatic model_write(input int base, input int data[$]);
        foreach (data[i]) begin
            wr_t e;
            e.addr = (base + i) % AMOD;
            e.data = data[i];
            exp_wr_q.push_back(e);
        end
    endtask

    task automatic model_read(input int base, input int len);
        for (int i = 0; i < len; i++) exp_rd_q.push_back((base + i) % AMOD);
    endtask

    // Compare process: every presented write and every returned read word
    // is checked against the model.
    int  prev_addr = 0;
    wr_t ce;
    int  ca;
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_address), 32'hFFFFFFFF);
            end else begin
                ce = exp_wr_q.pop_front();
                chk("write_addr", 32'(mem_address), 32'(ce.addr));
                chk("write_data", 32'(mem_data), 32'(ce.data));
                shadow[ce.addr] = 24'(ce.data);
            end
        end
        if (rd_valid === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFFFFFF);
            end else begin
                ca = exp_rd_q.pop_front();
                chk("read_addr", 32'(prev_addr), 32'(ca));
                chk("read_data", 32'(rd_data), 32'(shadow_rd(ca)));
            end
        end
        if (done === 1'b1) begin
            chk("done_rdvalid_overlap", 32'(rd_valid), 0);
            chk("done_busy", 32'(busy), 0);
            chk("done_pending_words", 32'(exp_wr_q.size() + exp_rd_q.size()), 0);
        end
        prev_addr = int'(mem_address);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic cmd(input bit w, input int base, input int len);
        start = 1'b1; op_write = w;
        base_addr = ADDR_W'(base); length = LEN_W'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input int d);
        bit fired = 1'b0;
        wr_valid = 1'b1; wr_data = DATA_W'(d);
        for (int i = 0; i < 8; i++) begin
            if (wr_ready === 1'b1) begin
                tick(); fired = 1'b1; break;
            end
            tick();
        end
        wr_valid = 1'b0;
        chk("wr_handshake", 32'(fired), 1);
        smp();
        chk("wr_wren", 32'(mem_wren), 1);
        chk("wr_data_out", 32'(mem_data), 32'(d));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b0;
            tick(); smp();
            chk("wr_gap_wren", 32'(mem_wren), 0);
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            smp();
            if (done === 1'b1) begin n = i; break; end
        end
        smp();
        chk("done_one_cycle", 32'(done), 0);
    endtask

    task automatic read_burst(input int base, input int len, output int data[$],
                              output int addrs[$], output int first, output int last,
                              output int done_idx);
        data.delete(); addrs.delete();
        first = -1; last = -1; done_idx = -1;
        model_read(base, len);
        cmd(1'b0, base, len);
        for (int i = 1; i <= 40; i++) begin
            smp();
            if (i <= len) addrs.push_back(int'(mem_address));
            if (rd_valid === 1'b1) begin
                data.push_back(int'(rd_data));
                if (first < 0) first = i;
                last = i;
            end
            if (done === 1'b1) begin done_idx = i; break; end
        end
        // Address at negedge i, data one cycle later, done right after.
        chk("rd_first_valid_cycle", 32'(first), 2);
        chk("rd_last_valid_cycle", 32'(last), 32'(len + 1));
        chk("rd_done_cycle", 32'(done_idx), 32'(len + 2));
        chk("rd_word_count", 32'(data.size()), 32'(len));
        smp();
        chk("rd_done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wd[$];
        int rd[$];
        int ad[$];
        int n, f, l, di, dcount;

        rst = 1'b1; start = 1'b0; op_write = 1'b0; base_addr = '0;
        length = '0; wr_data = '0; wr_valid = 1'b0;
        repeat (3) tick();
        smp();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        rst = 1'b0;
        tick();

        // Single-word write then readback.
        wd = {255};
        model_write(0, wd);
        cmd(1'b1, 0, 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_wr_ready", 32'(wr_ready), 1);
        send_word(255);
        chk("t1_addr", 32'(mem_address), 0);
        wait_done(n);
        chk("t1_done_latency", 32'(n), 1);
        read_burst(0, 1, rd, ad, f, l, di);
        chk("t1_rd_addr", 32'(ad[0]), 0);
        chk("t1_rd_data", 32'(rd[0]), 255);

        // Four words with a two-cycle gap in wr_valid.
        wd = {65535, 1, 2, 3};
        model_write(10, wd);
        cmd(1'b1, 10, 4);
        send_word(65535);
        send_word(1);
        gap(2);
        send_word(2);
        send_word(3);
        chk("t2_last_addr", 32'(mem_address), 13);
        wait_done(n);
        chk("t2_done_latency", 32'(n), 1);
        read_burst(10, 4, rd, ad, f, l, di);
        chk("t2_rd0", 32'(rd[0]), 65535);
        chk("t2_rd1", 32'(rd[1]), 1);
        chk("t2_rd2", 32'(rd[2]), 2);
        chk("t2_rd3", 32'(rd[3]), 3);

        // Address wrap at the top of memory.
        read_burst(32'h3FFFF, 3, rd, ad, f, l, di);
        chk("t3_addr0", 32'(ad[0]), 32'h3FFFF);
        chk("t3_addr1", 32'(ad[1]), 0);
        chk("t3_addr2", 32'(ad[2]), 1);
        chk("t3_rd_wrapped", 32'(rd[1]), 255);

        // start while busy must be ignored.
        wd = {7, 8, 9};
        model_write(50, wd);
        cmd(1'b1, 50, 3);
        send_word(7);
        start = 1'b1; op_write = 1'b0; base_addr = ADDR_W'(999); length = LEN_W'(2);
        tick();
        start = 1'b0;
        smp();
        send_word(8);
        send_word(9);
        chk("t4_last_addr", 32'(mem_address), 52);
        wait_done(n);
        chk("t4_done_latency", 32'(n), 1);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        chk("t4_no_second_burst", 32'(dcount), 0);

        // Zero-length commands.
        cmd(1'b1, 123, 0);
        smp();
        chk("t5w_done", 32'(done), 1);
        chk("t5w_busy", 32'(busy), 0);
        chk("t5w_wren", 32'(mem_wren), 0);
        smp();
        chk("t5w_done_off", 32'(done), 0);
        cmd(1'b0, 5, 0);
        smp();
        chk("t5r_done", 32'(done), 1);
        chk("t5r_busy", 32'(busy), 0);
        smp();
        chk("t5r_done_off", 32'(done), 0);
        chk("t5r_rd_valid", 32'(rd_valid), 0);

        // Reset in the middle of a write burst.
        wd = {3444, 3445, 100, 101, 102};
        model_write(200000, wd);
        cmd(1'b1, 200000, 5);
        send_word(3444);
        send_word(3445);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_wr_q.delete();
        smp();
        chk("t6_wren", 32'(mem_wren), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_wr_ready", 32'(wr_ready), 0);
        chk("t6_done", 32'(done), 0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            if (done === 1'b1 || mem_wren === 1'b1) dcount++;
        end
        chk("t6_no_done_after_rst", 32'(dcount), 0);
        read_burst(200000, 5, rd, ad, f, l, di);
        chk("t6_rd0", 32'(rd[0]), 3444);
        chk("t6_rd1", 32'(rd[1]), 3445);
        chk("t6_rd2_untouched", 32'(rd[2]), 32'(init_pat(200002)));

        repeat (3) smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for one port of the dual-port main memory (18-bit word address, 24-bit data, memory clocked on the inverted system clock). It accepts a burst command (base address, length, direction), drives address/data/write-enable one word per cycle, streams write data in via a valid/ready handshake, and returns read data as a valid-qualified stream. It sits between the vector/processing datapath and `mainMemory` port A or B, one instance per port.

## Interface
- `ADDR_W`, 18, memory word-address width
- `DATA_W`, 24, memory word width
- `LEN_W`, 10, burst-length width (max burst 2^LEN_W-1 words)
- `RD_LAT`, 1, clock edges from registered address to valid `mem_q` (legal 1..3)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe, sampled only in IDLE
- `op_write`  in  1  1 = write burst, 0 = read burst (sampled with `start`)
- `base_addr`  in  ADDR_W  first word address
- `length`  in  LEN_W  number of words
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `wr_data`  in  DATA_W  write stream data
- `wr_valid`  in  1  write stream valid
- `wr_ready`  out  1  high in WRITE state while words remain
- `rd_data`  out  DATA_W  read stream data
- `rd_valid`  out  1  read stream valid (no backpressure)
- `mem_address`  out  ADDR_W  to memory `address_x`
- `mem_data`  out  DATA_W  to memory `data_x`
- `mem_wren`  out  1  to memory `wren_x`
- `mem_q`  in  DATA_W  from memory `q_x`

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr`, `length`, `op_write`; length 0 → DONE; else → WRITE or READ. `start` in any other state ignored.
- WRITE: each cycle `wr_valid && wr_ready` issues one word: `mem_address`=current address, `mem_data`=`wr_data`, `mem_wren`=1 (registered). Cycles without a handshake drive `mem_wren`=0. After last word → DONE.
- READ: issues one address per cycle, `mem_wren`=0; a valid token enters an RD_LAT-deep shift pipe per issued address. After last address → DRAIN.
- DRAIN: waits until pipe empty → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- Address counter increments by 1 modulo 2^ADDR_W: 0x3FFFF wraps to 0x00000.
- Remaining-word counter is LEN_W wide; never underflows.
- Port conflicts with the other memory port are not arbitrated here.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `mem_wren`=0, `mem_address`=0, `mem_data`=0, state IDLE, pipe cleared.
- `start` accepted at edge E → `busy`=1 and `wr_ready`=1 (write) or first address on `mem_address` (read) at edge E+1.
- Write: handshake at edge K → `mem_*` valid from edge K+1; memory commits at the following negedge. `done` asserts the cycle after the last write is presented (`mem_wren`=0 during `done`).
- Read: address registered at edge A → `rd_data` = `mem_q` captured at edge A+RD_LAT, `rd_valid` high for that cycle. Back-to-back reads give one `rd_valid` per cycle, in address order.
- `done` asserts the cycle after the last `rd_valid`; `rd_valid` and `done` never overlap.
- Length-0 command: `done` at E+1, `busy` never asserts, no memory access.
- `rst` mid-burst: at the reset edge all outputs take reset values, in-flight read tokens discarded, no `done` pulse, `mem_wren` low in the next cycle.

## Test plan
- Reset then write length 1, base 0, `wr_data`=255 → one cycle `mem_wren`=1 at address 0, `done` next cycle; read length 1 from 0 → `rd_data`=255 with `rd_valid` 1 cycle after address.
- Write burst length 4 at base 10, data 65535,1,2,3 with `wr_valid` dropped for 2 cycles mid-burst → `mem_wren` gaps match, addresses 10..13; readback returns 65535,1,2,3 on 4 consecutive cycles.
- Read burst length 3 at base 0x3FFFF → addresses 0x3FFFF, 0x00000, 0x00001; `done` after third `rd_valid`.
- `start` pulsed while `busy` with different base → ignored; first burst completes unchanged.
- Length 0 → `done` next cycle, `mem_wren` never high, `rd_valid` never high.
- Assert `rst` during write burst at base 200000 after 2 of 5 words → `mem_wren`=0 next cycle, `busy`=0, no `done`; only addresses 200000 and 200001 modified (readback 3444 at 200000).
